// File: rtl/wb_pkg.sv
// Shared types and default widths for the write-back source selector.
package wb_pkg;

  localparam int WB_WIDTH  = 16;
  localparam int WB_ADDR_W = 4;

  typedef enum logic [1:0] {
    WB_SRC0 = 2'b00,
    WB_SRC1 = 2'b01,
    WB_SRC2 = 2'b10,
    WB_SRC3 = 2'b11
  } wb_sel_e;

endpackage : wb_pkg

// File: rtl/writeback_mux_mux4.sv
// Parameterised 4:1 combinational mux; an unknown select yields all-X in simulation.
module mux4
  import wb_pkg::*;
#(
  parameter int WIDTH = WB_WIDTH
) (
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  input  wb_sel_e          sel,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    // NOTE: combinational logic uses blocking '=' and assigns result on every
    // path (the default arm included) so no latch is inferred.
    case (sel)
      WB_SRC0: result = data0;
      WB_SRC1: result = data1;
      WB_SRC2: result = data2;
      WB_SRC3: result = data3;
      default: result = 'x;  // X/Z select: don't-care for synthesis
    endcase
  end

endmodule : mux4

// File: rtl/writeback_mux.sv
// Write-back source selector: combinational result plus a one-cycle registered
// copy with destination address and write enable for the register-file port.
module writeback_mux
  import wb_pkg::*;
#(
  parameter int WIDTH  = WB_WIDTH,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  data0,
  input  logic [WIDTH-1:0]  data1,
  input  logic [WIDTH-1:0]  data2,
  input  logic [WIDTH-1:0]  data3,
  input  logic [1:0]        select,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic [WIDTH-1:0]  result,
  output logic [WIDTH-1:0]  wb_data_q,
  output logic [ADDR_W-1:0] wb_addr_q,
  output logic              wb_we_q
);

  mux4 #(
    .WIDTH (WIDTH)
  ) u_mux4 (
    .data0  (data0),
    .data1  (data1),
    .data2  (data2),
    .data3  (data3),
    .sel    (wb_sel_e'(select)),
    .result (result)
  );

  // Write enable follows wb_en every cycle; data and address only load on a request.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      wb_we_q   <= 1'b0;
      wb_data_q <= '0;
      wb_addr_q <= '0;
    end else begin
      wb_we_q <= wb_en;
      if (wb_en) begin
        wb_data_q <= result;
        wb_addr_q <= wb_addr;
      end
    end
  end

endmodule : writeback_mux

// File: tb/tb_writeback_mux.sv
// Directed self-checking bench for writeback_mux with hand-computed expectations.
module tb_writeback_mux;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic [WIDTH-1:0]  data0, data1, data2, data3;
  logic [1:0]        select;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [WIDTH-1:0]  result;
  logic [WIDTH-1:0]  wb_data_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic              wb_we_q;

  int checks = 0;
  int errors = 0;

  writeback_mux #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data0     (data0),
    .data1     (data1),
    .data2     (data2),
    .data3     (data3),
    .select    (select),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .result    (result),
    .wb_data_q (wb_data_q),
    .wb_addr_q (wb_addr_q),
    .wb_we_q   (wb_we_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Expected back-to-back results, indexed by select.
  logic [WIDTH-1:0] exp_data [4];

  initial begin
    exp_data[0] = 16'h1234;
    exp_data[1] = 16'h0022;
    exp_data[2] = 16'h9ABC;
    exp_data[3] = 16'hDEF0;

    rst     = 1'b1;
    data0   = 16'h1234;
    data1   = 16'h0022;
    data2   = 16'h9ABC;
    data3   = 16'hDEF0;
    select  = 2'd0;
    wb_en   = 1'b1;
    wb_addr = 4'hF;

    // Reset state, with wb_en high to show reset dominates the edge.
    #1;
    check("rst_data", 32'(wb_data_q), 32'h0);
    check("rst_addr", 32'(wb_addr_q), 32'h0);
    check("rst_we",   32'(wb_we_q),   32'h0);
    @(posedge clk); #1;
    check("rst_hold_we",   32'(wb_we_q),   32'h0);
    check("rst_hold_data", 32'(wb_data_q), 32'h0);

    // Combinational sweep of all selects (reset still held: result unaffected).
    for (int i = 0; i < 4; i++) begin
      select = 2'(i);
      #0.1;
      check($sformatf("sweep_sel%0d", i), 32'(result), 32'(exp_data[i]));
      #9.9;
    end

    // Data change on the selected input, then on unselected ones.
    select = 2'd2;
    data2  = 16'h5555;
    #0.1;
    check("data2_follow", 32'(result), 32'h5555);
    data0 = 16'hAAAA; data1 = 16'hBBBB; data3 = 16'hCCCC;
    #0.1;
    check("others_ignored", 32'(result), 32'h5555);
    data0 = 16'h1234; data1 = 16'h0022; data2 = 16'h9ABC; data3 = 16'hDEF0;

    // Release reset with wb_en low.
    @(negedge clk);
    wb_en = 1'b0;
    rst   = 1'b0;

    // Single registered capture, then hold.
    @(negedge clk);
    select  = 2'd1;
    wb_en   = 1'b1;
    wb_addr = 4'hA;
    @(posedge clk); #1;
    check("cap_data", 32'(wb_data_q), 32'h0022);
    check("cap_addr", 32'(wb_addr_q), 32'hA);
    check("cap_we",   32'(wb_we_q),   32'h1);
    wb_en   = 1'b0;
    select  = 2'd3;
    wb_addr = 4'h7;
    @(posedge clk); #1;
    check("hold_we",   32'(wb_we_q),   32'h0);
    check("hold_data", 32'(wb_data_q), 32'h0022);
    check("hold_addr", 32'(wb_addr_q), 32'hA);

    // Select changes within the request cycle: the edge-time value wins.
    @(negedge clk);
    wb_en   = 1'b1;
    select  = 2'd1;
    wb_addr = 4'h6;
    #3;
    select  = 2'd2;
    @(posedge clk); #1;
    check("late_sel_data", 32'(wb_data_q), 32'h9ABC);
    check("late_sel_addr", 32'(wb_addr_q), 32'h6);

    // Back-to-back writes.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      select  = 2'(i);
      wb_addr = 4'(i + 1);
      wb_en   = 1'b1;
      @(posedge clk); #1;
      check($sformatf("b2b_data%0d", i), 32'(wb_data_q), 32'(exp_data[i]));
      check($sformatf("b2b_addr%0d", i), 32'(wb_addr_q), 32'(i + 1));
      check($sformatf("b2b_we%0d", i),   32'(wb_we_q),   32'h1);
    end

    // Asynchronous reset mid-cycle while a write is pending on the outputs.
    #2;
    select = 2'd0;
    wb_en  = 1'b1;
    rst    = 1'b1;
    #0.5;
    check("async_data",   32'(wb_data_q), 32'h0);
    check("async_addr",   32'(wb_addr_q), 32'h0);
    check("async_we",     32'(wb_we_q),   32'h0);
    check("async_result", 32'(result),    32'h1234);
    @(posedge clk); #1;
    check("async_discard_we", 32'(wb_we_q), 32'h0);

    // Reset release with a request waiting.
    @(negedge clk);
    wb_addr = 4'h5;
    rst     = 1'b0;
    @(posedge clk); #1;
    check("rel_data", 32'(wb_data_q), 32'h1234);
    check("rel_addr", 32'(wb_addr_q), 32'h5);
    check("rel_we",   32'(wb_we_q),   32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_writeback_mux

// File: doc/writeback_mux.md
Name: writeback_mux

Overview:
- Write-back source selector for the CPU pipeline.
- Picks one of four WIDTH-bit candidate values (e.g. ALU, memory, immediate, vector unit) with a 2-bit select and presents it combinationally on `result`.
- Also provides a one-cycle registered copy of the selected value, with register-file write address and write enable, for the register-file write port.

Parameters:
- WIDTH, 16, data width of every source and of the result.
- ADDR_W, 4, register-file destination address width.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- data0  input  WIDTH  source 0, selected when select=2'b00.
- data1  input  WIDTH  source 1, selected when select=2'b01.
- data2  input  WIDTH  source 2, selected when select=2'b10.
- data3  input  WIDTH  source 3, selected when select=2'b11.
- select  input  2  source select.
- wb_en  input  1  write-back request this cycle.
- wb_addr  input  ADDR_W  destination register for this request.
- result  output  WIDTH  combinational selected value.
- wb_data_q  output  WIDTH  registered selected value.
- wb_addr_q  output  ADDR_W  registered destination address.
- wb_we_q  output  1  registered write enable.

Behaviour:
- result is purely combinational and has zero latency: result = data[select].
  - Any change on select or on the selected data input is reflected in the same delta cycle.
  - No clock is involved.
- All four select encodings are valid; there is no default or illegal case.
- A select containing X/Z drives result to all-X in simulation. Synthesis treats it as don't-care.
- Sources are used bit-for-bit with no sign or zero extension inside the block. Callers drive full-WIDTH values (e.g. an 8-bit 8'h22 arrives as 16'h0022).
- Registered path, at each rising clk edge when rst=0:
  - wb_we_q <= wb_en.
  - If wb_en=1: wb_data_q <= result and wb_addr_q <= wb_addr.
  - If wb_en=0: wb_data_q and wb_addr_q hold their previous values.
- Registered-path latency is exactly 1 cycle from a sampled wb_en=1 to wb_we_q=1 with matching data and address.
- Reset:
  - rst=1 immediately (asynchronously) forces wb_data_q=0, wb_addr_q=0 and wb_we_q=0.
  - All three stay at those values while rst is held.
  - The first capture happens at the first rising edge after rst deasserts.
  - Reset does not affect result, which keeps tracking its inputs during reset.
- A reset asserted mid-operation discards any request sampled in that cycle; no write is issued.
- If select changes in the same cycle that wb_en=1, the capture uses the select value present at the clock edge.
- Back-to-back requests with wb_en=1 every cycle each produce a write on the following cycle.

Decomposition:
- Shared package `wb_pkg`:
  - enum wb_sel_e (2 bits): WB_SRC0=2'b00, WB_SRC1=2'b01, WB_SRC2=2'b10, WB_SRC3=2'b11.
  - Default widths WB_WIDTH=16 and WB_ADDR_W=4.
- One natural sub-module, `mux4`: a parameterised WIDTH 4:1 combinational mux.
  - writeback_mux instantiates it for result.
  - writeback_mux adds the write-back register stage around it.

Test Plan:
- Combinational sweep:
  - Stimulus: data0=16'h1234, data1=16'h0022, data2=16'h9ABC, data3=16'hDEF0; select stepped 0,1,2,3 at 10 ns intervals, no clock edges needed.
  - Response: result = 1234, 0022, 9ABC, DEF0 respectively, each valid within the same time step as the select change.
- Data change with select fixed:
  - Stimulus: select=2, then data2 changed 16'h9ABC -> 16'h5555.
  - Response: result follows to 5555 immediately; the other data inputs changing leaves result unchanged.
- Registered capture:
  - Stimulus: select=1, data1=16'h0022, wb_en=1, wb_addr=4'hA at one edge, then wb_en=0.
  - Response: after that edge wb_data_q=0022, wb_addr_q=A, wb_we_q=1; the next edge gives wb_we_q=0 with data and address held.
- Back-to-back writes:
  - Stimulus: wb_en=1 for 4 cycles with select 0,1,2,3 and wb_addr 1,2,3,4.
  - Response: the registered outputs show (1234,1), (0022,2), (9ABC,3), (DEF0,4) on consecutive cycles with wb_we_q=1 throughout.
- Asynchronous reset:
  - Stimulus: rst asserted between clock edges while wb_we_q=1 and wb_data_q=DEF0.
  - Response: wb_data_q=0, wb_addr_q=0, wb_we_q=0 immediately without waiting for a clock edge; result still equals data[select].
- Reset release:
  - Stimulus: rst deasserted with wb_en=1 and select=0.
  - Response: at the first rising edge after release, wb_data_q=1234 and wb_we_q=1.
